// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state, iteration counts and Booth digit encoding
// for the iterative multiply/divide unit.
package multdiv_pkg;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] MUL_ITER = CNT_W'(16);
    localparam logic [CNT_W-1:0] DIV_ITER = CNT_W'(32);
    typedef enum logic [2:0] {BZERO, BPOS1, BPOS2, BNEG1, BNEG2} boothDigit_t;
    function automatic boothDigit_t boothDecode(input logic [2:0] w);
        return (w == 3'b011) ? BPOS2 :
               (w == 3'b100) ? BNEG2 :
               (w == 3'b001 || w == 3'b010) ? BPOS1 :
               (w == 3'b101 || w == 3'b110) ? BNEG1 : BZERO;
    endfunction
endpackage

// File: rtl/booth_radix4_step.sv
// booth_radix4_step: maps a 3-bit multiplier window to the addend 0, +-B or +-2B.
module booth_radix4_step
    import multdiv_pkg::*;
(
    input  logic [2:0]  window,
    input  logic [33:0] bExt,
    output logic [33:0] addend
);
    boothDigit_t digit;
    logic [33:0] mag;
    always_comb begin
        digit = boothDecode(window);
        mag = (digit == BPOS2 || digit == BNEG2) ? bExt << 1 : bExt;
        addend = (digit == BZERO) ? '0 : (digit == BNEG1 || digit == BNEG2) ? -mag : mag;
    end
endmodule

// File: rtl/execute_multdiv.sv
// execute_multdiv: iterative signed 32-bit radix-4 Booth multiply and
// non-restoring divide sharing one 66-bit accumulator.
module execute_multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t state;
    logic [CNT_W-1:0] iterCnt;
    logic [65:0] acc;
    logic [33:0] opB;
    logic boothPrev, negA, negB;
    logic [33:0] addend, boothSum, remShift, remNext;
    logic [31:0] magA, magB, quotient;
    logic mulOvf, divZero;

    booth_radix4_step uStep (
        .window ({acc[1:0], boothPrev}),
        .bExt   (opB),
        .addend (addend)
    );

    // In DIV, acc is {remainder[33:0], quotient[31:0]} and opB holds |B|.
    always_comb begin
        magA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        magB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        boothSum = acc[65:32] + addend;
        remShift = acc[64:31];
        remNext = acc[65] ? remShift + opB : remShift - opB;
        quotient = (negA ^ negB) ? -acc[31:0] : acc[31:0];
        mulOvf = !((&acc[63:31]) || !(|acc[63:31]));
        divZero = ~|opB;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            iterCnt <= '0;
            acc <= '0;
            opB <= '0;
            boothPrev <= 1'b0;
            negA <= 1'b0;
            negB <= 1'b0;
            data_result <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                state <= MUL;
                busy <= 1'b1;
                iterCnt <= '0;
                acc <= {34'b0, data_operandA};
                opB <= {{2{data_operandB[WIDTH-1]}}, data_operandB};
                boothPrev <= 1'b0;
            end else if (ctrl_DIV) begin
                state <= DIV;
                busy <= 1'b1;
                iterCnt <= '0;
                acc <= {34'b0, magA};
                opB <= {2'b0, magB};
                negA <= data_operandA[WIDTH-1];
                negB <= data_operandB[WIDTH-1];
            end else begin
                case (state)
                    MUL: begin
                        if (iterCnt == MUL_ITER) begin
                            state <= DONE;
                            busy <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result <= acc[31:0];
                            data_exception <= mulOvf;
                        end else begin
                            acc <= {{2{boothSum[33]}}, boothSum, acc[31:2]};
                            boothPrev <= acc[1];
                            iterCnt <= iterCnt + CNT_W'(1);
                        end
                    end
                    DIV: begin
                        if (iterCnt == DIV_ITER || divZero) begin
                            state <= DONE;
                            busy <= 1'b0;
                            data_resultRDY <= 1'b1;
                            data_result <= divZero ? '0 : quotient;
                            // Only INT_MIN / -1 yields a positive quotient of 2^31.
                            data_exception <= divZero || (!(negA ^ negB) && acc[31]);
                        end else begin
                            acc <= {remNext, acc[30:0], ~remNext[33]};
                            iterCnt <= iterCnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/execute_multdiv.md
# execute_multdiv

Iterative signed 32-bit multiply/divide unit in the execute stage, beside the `alu`. The decode stage pulses `ctrl_MULT` or `ctrl_DIV` with two register operands. The unit returns a registered 32-bit result, an exception flag and a one-cycle ready pulse. The writeback mux selects between this result and the ALU's `data_result`.

## Interface
- `WIDTH`, default 32: operand and result width; only 32 is supported.
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `data_operandA` input 32: multiplicand or dividend, signed two's complement.
- `data_operandB` input 32: multiplier or divisor, signed two's complement.
- `ctrl_MULT` input 1: start-multiply pulse, sampled on a rising edge.
- `ctrl_DIV` input 1: start-divide pulse, sampled on a rising edge.
- `data_result` output 32: low 32 bits of the product, or the quotient.
- `data_exception` output 1: overflow or divide-by-zero flag, valid with the result.
- `data_resultRDY` output 1: result valid, high for exactly one cycle.
- `busy` output 1: an operation is in flight.

## Operation
- Reset (asynchronous, `reset_n`=0): state goes to IDLE. `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
- States: IDLE, MUL, DIV, DONE.
- Start rule: a start is sampled on any edge, in any state.
  - Operands are latched at the start edge. They are not required to stay stable afterwards.
  - If `ctrl_MULT` and `ctrl_DIV` are both high, MULT wins.
  - A start while `busy`=1 aborts the current operation and restarts with the new operands. The aborted operation never asserts RDY.
- MUL: radix-4 Booth, 16 iterations.
  - Each iteration adds one of {0, ±B, ±2B} into a 66-bit partial-product register, then arithmetic-shifts right by 2.
  - `data_result` = product[31:0].
  - `data_exception` = 1 iff product[63:31] is not all-equal, i.e. the true product does not fit in signed 32 bits.
- DIV: non-restoring division on magnitudes, 32 iterations.
  - The sign is corrected at DONE. The quotient truncates toward zero; the remainder is discarded.
  - B = 0: go straight to DONE. `data_result`=0, `data_exception`=1.
  - A = 0x80000000 and B = 0xFFFFFFFF: `data_result`=0x80000000, `data_exception`=1, with full latency.
- DONE: `data_result` and `data_exception` are registered. `data_resultRDY`=1 for this one cycle, then the state returns to IDLE.
- Result hold: `data_result` and `data_exception` hold their values until the next DONE.
  - They do not clear at a start.
  - Consumers must qualify them with `data_resultRDY`.
- `busy` = 1 in MUL and DIV, and 0 in IDLE and DONE.

## Timing
- Start sampled at edge k:
  - Multiply: iterations at edges k+1..k+16. DONE is entered at edge k+17, so RDY is high from k+17 to k+18.
  - Divide: iterations at edges k+1..k+32. DONE is entered at k+33, so RDY is high from k+33 to k+34.
  - Divide-by-zero: DONE is entered at edge k+1.
- Back-to-back: a start sampled in the DONE cycle is accepted. RDY for the old operation still completes, and the new operation's latency counts from that edge.
- Reset mid-operation: the next edge sees IDLE, no RDY is generated, and the outputs are cleared as in reset.
- Combinational paths: none from inputs to outputs. All outputs come from flops.

## Structure
- Package `multdiv_pkg`:
  - State enum {IDLE, MUL, DIV, DONE}.
  - `MUL_ITER`=16 and `DIV_ITER`=32.
  - Iteration-counter width of 6 bits.
  - Booth digit encoding.
- Sub-module `booth_radix4_step`, purely combinational:
  - Inputs: the 3-bit multiplier window and the 34-bit sign-extended B.
  - Output: the signed addend.
- The top level holds:
  - the FSM and the iteration counter;
  - the shared 66-bit accumulator/shift register, reused as remainder:quotient in DIV;
  - the operand-sign flops.

## Test plan
- MULT: A=7, B=-3 → RDY at k+17; result 0xFFFFFFEB, exception 0; RDY high for exactly one cycle.
- MULT overflow: A=0x00010000, B=0x00010000 → result 0x00000000, exception 1. Also A=0x80000000, B=1 → result 0x80000000, exception 0.
- DIV: A=-7, B=2 → RDY at k+33, result 0xFFFFFFFD (-3), exception 0. Also A=100, B=-10 → result -10.
- DIV special cases: B=0 → RDY at k+1, result 0, exception 1. Also A=0x80000000, B=-1 → result 0x80000000, exception 1.
- Abort and conflicting start:
  - Start MULT 5×5, then DIV 9/3 at k+5 → only one RDY, at k+5+33, with result 3.
  - MULT and DIV high together → multiply latency and a product result.
- Reset: assert `reset_n`=0 mid-DIV at k+10 → outputs 0 immediately; no RDY within 40 cycles after release.
- Random self-check: 10k signed operand pairs against the bench's 64-bit and truncating-divide reference.
